alu_md_unit: RTL and testbench
==============================

ALU_MD_UNIT -- requirements
Module: alu_md_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 Port: i_clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: i_rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: i_valid  input  1  operation request, sampled when o_ready=1.
REQ-005 Port: i_alu_ctl  input  2  00 add, 01 sub, 10 decode by funct fields, 11 reserved.
REQ-006 Port: i_f3  input  3  instruction funct3.
REQ-007 Port: i_f7_bit6  input  1  funct7[5] (sub/sra select).
REQ-008 Port: i_f7_bit0  input  1  funct7[0] (M-extension select).
REQ-009 Port: i_a, i_b  input  XLEN each  operands.
REQ-010 Port: i_kill  input  1  abort in-flight operation.
REQ-011 Port: o_ready  output  1  unit idle, request accepted this cycle if i_valid=1.
REQ-012 Port: o_valid  output  1  one-cycle pulse, o_result valid.
REQ-013 Port: o_result  output  XLEN  registered result, held until next o_valid.

Function
REQ-014 States SHALL be IDLE, MUL, DIV, DONE; o_ready=1 only in IDLE.
REQ-015 Decode, i_alu_ctl=10, i_f7_bit0=0: f3 000 add (sub if i_f7_bit6), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (sra if i_f7_bit6), 110 or, 111 and; i_alu_ctl=11 SHALL execute add.
REQ-016 Shift amount SHALL be i_b[log2(XLEN)-1:0]; add/sub wrap modulo 2^XLEN; slt signed, sltu unsigned, result 0 or 1 zero-extended.
REQ-017 Single-cycle ops: accepted at edge N -> IDLE->DONE, o_valid=1 with result in cycle after edge N, then DONE->IDLE; latency 1, throughput 1 per 2 cycles.
REQ-018 M ops (i_alu_ctl=10, i_f7_bit0=1): f3 000 MUL (low XLEN bits), 100 DIV, 101 DIVU, 110 REM, 111 REMU; f3 001/010/011 SHALL return 0 with latency 1.
REQ-019 MUL SHALL be shift-add, one bit per cycle, XLEN cycles in MUL state, then DONE; latency XLEN+1.
REQ-020 DIV/DIVU/REM/REMU SHALL be restoring on magnitudes, XLEN cycles in DIV state, sign-corrected (quotient sign a^b, remainder sign of a), then DONE; latency XLEN+1.
REQ-021 Divide by zero SHALL bypass DIV state: quotient all ones, remainder = i_a, latency 1.
REQ-022 Signed overflow (a = most-negative, b = -1): quotient = most-negative, remainder 0, latency XLEN+1.
REQ-023 Operands and decoded op SHALL be latched at acceptance; input changes while busy SHALL not affect the result.
REQ-024 i_kill=1 in MUL/DIV/DONE SHALL force IDLE next edge, suppress o_valid, leave o_result unchanged; i_kill in IDLE ignored, i_kill with i_valid in IDLE accepts the request.
REQ-025 Iteration counter SHALL be log2(XLEN)+1 bits and reload at every acceptance.

Reset
REQ-026 i_rst=1 SHALL immediately set state IDLE, o_valid 0, o_result 0, counter 0, operand/accumulator registers 0, regardless of clock.
REQ-027 Reset mid-operation SHALL discard the operation with no o_valid; o_ready=1 on first cycle after deassertion.

Configuration
REQ-028 Macro ALU_MD_MEXT_EN defined: M ops, MUL/DIV states and datapath per REQ-018..REQ-022 present.
REQ-029 Macro ALU_MD_MEXT_EN undefined: i_f7_bit0 ignored, all decode per REQ-015, MUL/DIV states and iterative datapath absent, every op latency 1.

Verification
REQ-030 XLEN=32, alu_ctl=10, f3=000, f7_bit6=1, a=5, b=7 -> o_valid 1 cycle later, result 0xFFFFFFFE.
REQ-031 XLEN=32, f3=101, f7_bit6=1, a=0x80000000, b=0x24 -> sra by 4, result 0xF8000000.
REQ-032 ALU_MD_MEXT_EN, MUL a=0xFFFFFFFF, b=3 -> o_valid at cycle 33, result 0xFFFFFFFD; o_ready 0 cycles 1..33.
REQ-033 ALU_MD_MEXT_EN, DIV a=-7, b=2 -> quotient -3; REM -> -1; DIVU a=7, b=0 -> 0xFFFFFFFF after 1 cycle; REM a=0x80000000, b=-1 -> 0.
REQ-034 ALU_MD_MEXT_EN, DIV started, i_kill at cycle 10 -> no o_valid, o_ready 1 next cycle, o_result unchanged; repeat with i_rst at cycle 10 -> o_result 0.
REQ-035 XLEN=8, no macro, i_f7_bit0=1, f3=000, a=0x7F, b=1 -> add, result 0x80, latency 1.

Source files
------------

// File: rtl/alu_md_unit.sv
// alu_md_unit: integer ALU with one-cycle ops and an optional iterative multiply/divide unit.
// Define ALU_MD_MEXT_EN to build the M-extension datapath (MUL/DIV states, shift-add, restoring divide).
module alu_md_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [1:0]      i_alu_ctl,
  input  logic [2:0]      i_f3,
  input  logic            i_f7_bit6,
  input  logic            i_f7_bit0,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_kill,
  output logic            o_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] sra_res;
  logic [SHW-1:0]  shamt;

  assign shamt    = i_b[SHW-1:0];
  assign sra_res  = $signed(i_a) >>> shamt;
  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;

  // NOTE: every always_comb output is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res = i_a + i_b;
    if (i_alu_ctl == 2'b01) begin
      alu_res = i_a - i_b;
    end else if (i_alu_ctl == 2'b10) begin
      case (i_f3)
        3'b000:  alu_res = i_f7_bit6 ? (i_a - i_b) : (i_a + i_b);
        3'b001:  alu_res = i_a << shamt;
        3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
        3'b011:  alu_res = {{(XLEN-1){1'b0}}, (i_a < i_b)};
        3'b100:  alu_res = i_a ^ i_b;
        3'b101:  alu_res = i_f7_bit6 ? sra_res : (i_a >> shamt);
        3'b110:  alu_res = i_a | i_b;
        default: alu_res = i_a & i_b;
      endcase
    end
  end

`ifdef ALU_MD_MEXT_EN
  localparam int CW = SHW + 1;
  localparam logic [1:0]    S_MUL    = 2'd1;
  localparam logic [1:0]    S_DIV    = 2'd2;
  localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;   // MUL partial product / DIV partial remainder
  logic [XLEN-1:0] opa_q, opa_d;   // MUL multiplicand / DIV dividend shifting into quotient
  logic [XLEN-1:0] opb_q, opb_d;   // MUL multiplier / DIV divisor magnitude
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            rem_sel_q, rem_sel_d;

  logic            is_m;
  logic            div_signed;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] mul_acc;
  logic [XLEN:0]   rem_sh, rem_diff;
  logic [XLEN-1:0] div_quo, div_rem, div_res;

  assign is_m       = (i_alu_ctl == 2'b10) && i_f7_bit0;
  assign div_signed = ~i_f3[0];
  assign a_mag      = (div_signed && i_a[XLEN-1]) ? -i_a : i_a;
  assign b_mag      = (div_signed && i_b[XLEN-1]) ? -i_b : i_b;

  assign mul_acc  = acc_q + (opb_q[0] ? opa_q : '0);
  // Restoring step: shift the next dividend bit into the remainder, keep the difference if it did not go negative.
  assign rem_sh   = {acc_q, opa_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign div_quo  = {opa_q[XLEN-2:0], ~rem_diff[XLEN]};
  assign div_rem  = rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
  assign div_res  = rem_sel_q ? (neg_rem_q ? -div_rem : div_rem)
                              : (neg_quo_q ? -div_quo : div_quo);
`else
  logic unused_inputs;
  assign unused_inputs = i_f7_bit0 ^ i_kill;
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifdef ALU_MD_MEXT_EN
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    rem_sel_d = rem_sel_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d  = S_DONE;
          result_d = alu_res;
`ifdef ALU_MD_MEXT_EN
          cnt_d = CNT_LOAD;
          if (is_m) begin
            case (i_f3)
              3'b000: begin
                state_d = S_MUL;
                acc_d   = '0;
                opa_d   = i_a;
                opb_d   = i_b;
              end
              3'b100, 3'b101, 3'b110, 3'b111: begin
                if (i_b == '0) begin
                  result_d = i_f3[1] ? i_a : '1;
                end else begin
                  state_d   = S_DIV;
                  acc_d     = '0;
                  opa_d     = a_mag;
                  opb_d     = b_mag;
                  neg_quo_d = div_signed & (i_a[XLEN-1] ^ i_b[XLEN-1]);
                  neg_rem_d = div_signed & i_a[XLEN-1];
                  rem_sel_d = i_f3[1];
                end
              end
              default: result_d = '0;
            endcase
          end
`endif
        end
      end
`ifdef ALU_MD_MEXT_EN
      S_MUL: begin
        if (i_kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_acc;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d  = S_DONE;
            result_d = mul_acc;
          end
        end
      end
      S_DIV: begin
        if (i_kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_rem;
          opa_d = div_quo;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d  = S_DONE;
            result_d = div_res;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: flops take non-blocking assignments so every register samples the pre-edge value of the others.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

`ifdef ALU_MD_MEXT_EN
  // NOTE: the datapath registers are reset too, so an aborted operation leaves no stale operands behind.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      rem_sel_q <= rem_sel_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_md_unit.sv
// Self-checking bench for alu_md_unit (XLEN=32): transaction-level reference model compared every cycle,
// directed literal cases, then randomized stimulus with kills and resets. Honours ALU_MD_MEXT_EN if defined.
module tb_alu_md_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_alu_ctl = 2'b00;
  logic [2:0]  i_f3 = 3'b000;
  logic        i_f7_bit6 = 1'b0;
  logic        i_f7_bit0 = 1'b0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_kill = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Reference model: 0 = idle, 1 = iterating, 2 = result presented
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_res   = '0;
  logic [31:0] m_pend  = '0;

  always #5 i_clk = ~i_clk;

  alu_md_unit #(.XLEN(XLEN)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_alu_ctl (i_alu_ctl),
    .i_f3      (i_f3),
    .i_f7_bit6 (i_f7_bit6),
    .i_f7_bit0 (i_f7_bit0),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_kill    (i_kill),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_result  (o_result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model_res(input logic [1:0] ctl, input logic [2:0] f3, input logic b6,
                                            input logic b0, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    int unsigned sh;
    logic [31:0] r;
    sa = a;
    sb = b;
    sh = b % 32;
    if (ctl == 2'b01) return a - b;
    if (ctl != 2'b10) return a + b;
`ifdef ALU_MD_MEXT_EN
    if (b0) begin
      case (f3)
        3'b000: r = a * b;
        3'b100: begin
          if (b == 0) r = '1;
          else if (a == MIN_NEG && sb == -1) r = MIN_NEG;
          else r = sa / sb;
        end
        3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'b110: begin
          if (b == 0) r = a;
          else if (a == MIN_NEG && sb == -1) r = '0;
          else r = sa % sb;
        end
        3'b111: r = (b == 0) ? a : a % b;
        default: r = '0;
      endcase
      return r;
    end
`endif
    case (f3)
      3'b000: r = b6 ? a - b : a + b;
      3'b001: r = a << sh;
      3'b010: r = (sa < sb) ? 32'd1 : 32'd0;
      3'b011: r = (a < b) ? 32'd1 : 32'd0;
      3'b100: r = a ^ b;
      3'b101: begin
        if (b6) r = sa >>> sh;
        else r = a >> sh;
      end
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [1:0] ctl, input logic [2:0] f3, input logic b0,
                                   input logic [31:0] b);
`ifdef ALU_MD_MEXT_EN
    if (ctl == 2'b10 && b0 && (f3 == 3'b000 || (f3[2] && b != 0))) return XLEN + 1;
`endif
    return 1;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_res   <= '0;
      m_pend  <= '0;
    end else begin
      case (m_phase)
        0: if (i_valid) begin
          if (model_lat(i_alu_ctl, i_f3, i_f7_bit0, i_b) == 1) begin
            m_phase <= 2;
            m_res   <= model_res(i_alu_ctl, i_f3, i_f7_bit6, i_f7_bit0, i_a, i_b);
          end else begin
            m_phase <= 1;
            m_left  <= model_lat(i_alu_ctl, i_f3, i_f7_bit0, i_b) - 1;
            m_pend  <= model_res(i_alu_ctl, i_f3, i_f7_bit6, i_f7_bit0, i_a, i_b);
          end
        end
        1: begin
          if (i_kill) m_phase <= 0;
          else if (m_left == 1) begin
            m_phase <= 2;
            m_res   <= m_pend;
          end else m_left <= m_left - 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (cmp_en) begin
      check("cmp_ready", o_ready, (m_phase == 0));
      check("cmp_valid", o_valid, (m_phase == 2));
      check("cmp_result", o_result, m_res);
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!o_ready && n < 200) begin
      @(negedge i_clk); #1;
      n++;
    end
    if (!o_ready) check({name, "_ready_timeout"}, o_ready, 1);
  endtask

  task automatic do_op(input string name, input logic [1:0] ctl, input logic [2:0] f3, input logic b6,
                       input logic b0, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    bit ready_seen;
    wait_ready(name);
    i_valid = 1'b1; i_alu_ctl = ctl; i_f3 = f3; i_f7_bit6 = b6; i_f7_bit0 = b0; i_a = a; i_b = b;
    @(negedge i_clk); #1;
    // Scramble operands after acceptance: the result must come from the latched copies
    i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_f3 = 3'($urandom); i_f7_bit6 = 1'($urandom);
    cyc = 1;
    ready_seen = 1'b0;
    while (!o_valid && cyc < 200) begin
      ready_seen |= o_ready;
      @(negedge i_clk); #1;
      cyc++;
    end
    ready_seen |= o_ready;
    check({name, "_lat"}, cyc, exp_lat);
    check({name, "_busy"}, ready_seen, 0);
    check(name, o_result, exp_res);
  endtask

  initial begin : main
    bit vseen;
    #1 i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    #1;
    check("reset_ready", o_ready, 1);
    check("reset_valid", o_valid, 0);
    check("reset_result", o_result, 0);
    cmp_en = 1'b1;
    i_rst = 1'b0;
    @(negedge i_clk); #1;
    check("ready_after_reset", o_ready, 1);

    do_op("sub_5_7",       2'b10, 3'b000, 1'b1, 1'b0, 32'd5,        32'd7,        32'hFFFF_FFFE, 1);
    do_op("sra_shamt_low", 2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h24,      32'hF800_0000, 1);
    do_op("srl",           2'b10, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h24,      32'h0800_0000, 1);
    do_op("sll_31",        2'b10, 3'b001, 1'b0, 1'b0, 32'd1,        32'h3F,       32'h8000_0000, 1);
    do_op("slt_signed",    2'b10, 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd1,         1);
    do_op("sltu",          2'b10, 3'b011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0,         1);
    do_op("xor",           2'b10, 3'b100, 1'b0, 1'b0, 32'hFF,       32'h0F,       32'hF0,        1);
    do_op("or",            2'b10, 3'b110, 1'b0, 1'b0, 32'hA0,       32'h0F,       32'hAF,        1);
    do_op("and",           2'b10, 3'b111, 1'b0, 1'b0, 32'hF0,       32'h3C,       32'h30,        1);
    do_op("add_wrap",      2'b00, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0,         1);
    do_op("sub_ctl",       2'b01, 3'b000, 1'b0, 1'b0, 32'd0,        32'd1,        32'hFFFF_FFFF, 1);
    do_op("reserved_add",  2'b11, 3'b101, 1'b1, 1'b0, 32'd2,        32'd3,        32'd5,         1);
    i_kill = 1'b1;
    do_op("kill_idle_accept", 2'b10, 3'b000, 1'b0, 1'b0, 32'd10,    32'd20,       32'd30,        1);
    i_kill = 1'b0;

    // Asynchronous reset while the result is being presented
    wait_ready("rst_done");
    i_valid = 1'b1; i_alu_ctl = 2'b00; i_a = 32'd40; i_b = 32'd2;
    @(negedge i_clk); #1;
    i_valid = 1'b0;
    check("pre_rst_valid", o_valid, 1);
    i_rst = 1'b1; #1;
    check("rst_done_valid", o_valid, 0);
    check("rst_done_result", o_result, 0);
    @(negedge i_clk); #1;
    i_rst = 1'b0;
    check("rst_done_ready", o_ready, 1);

`ifdef ALU_MD_MEXT_EN
    do_op("mul_neg1_x3",   2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3,       32'hFFFF_FFFD, 33);
    do_op("div_m7_2",      2'b10, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 33);
    do_op("rem_m7_2",      2'b10, 3'b110, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 33);
    do_op("divu_by_zero",  2'b10, 3'b101, 1'b0, 1'b1, 32'd7,        32'd0,        32'hFFFF_FFFF, 1);
    do_op("remu_by_zero",  2'b10, 3'b111, 1'b0, 1'b1, 32'h1234,     32'd0,        32'h1234,      1);
    do_op("rem_overflow",  2'b10, 3'b110, 1'b0, 1'b1, MIN_NEG,      32'hFFFF_FFFF, 32'd0,        33);
    do_op("div_overflow",  2'b10, 3'b100, 1'b0, 1'b1, MIN_NEG,      32'hFFFF_FFFF, MIN_NEG,      33);
    do_op("m_f3_001_zero", 2'b10, 3'b001, 1'b0, 1'b1, 32'd5,        32'd6,        32'd0,         1);
    do_op("divu_big",      2'b10, 3'b101, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd16,      32'h0FFF_FFFF, 33);

    // Kill ten cycles into a divide
    do_op("pre_kill",      2'b00, 3'b000, 1'b0, 1'b0, 32'h1200,     32'h34,       32'h1234,      1);
    wait_ready("kill_div");
    i_valid = 1'b1; i_alu_ctl = 2'b10; i_f3 = 3'b100; i_f7_bit0 = 1'b1; i_a = 32'd100; i_b = 32'd3;
    @(negedge i_clk); #1;
    i_valid = 1'b0;
    repeat (9) begin @(negedge i_clk); #1; end
    i_kill = 1'b1;
    @(negedge i_clk); #1;
    i_kill = 1'b0;
    check("kill_ready", o_ready, 1);
    check("kill_result_held", o_result, 32'h1234);
    vseen = 1'b0;
    repeat (40) begin vseen |= o_valid; @(negedge i_clk); #1; end
    check("kill_no_valid", vseen, 0);

    // Reset ten cycles into a divide
    i_valid = 1'b1; i_alu_ctl = 2'b10; i_f3 = 3'b100; i_f7_bit0 = 1'b1; i_a = 32'd100; i_b = 32'd3;
    @(negedge i_clk); #1;
    i_valid = 1'b0;
    repeat (9) begin @(negedge i_clk); #1; end
    i_rst = 1'b1; #1;
    check("rst_mid_result", o_result, 0);
    check("rst_mid_valid", o_valid, 0);
    @(negedge i_clk); #1;
    i_rst = 1'b0;
    check("rst_mid_ready", o_ready, 1);
    vseen = 1'b0;
    repeat (40) begin vseen |= o_valid; @(negedge i_clk); #1; end
    check("rst_mid_no_valid", vseen, 0);
`else
    do_op("f7_bit0_ignored", 2'b10, 3'b000, 1'b0, 1'b1, 32'h7F,     32'd1,        32'h80,        1);
    do_op("f7_bit0_div_f3",  2'b10, 3'b100, 1'b0, 1'b1, 32'h0F,     32'h05,       32'h0A,        1);
`endif

    // Randomized traffic; the compare process checks every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      i_valid   = 1'($urandom_range(0, 1));
      i_kill    = ($urandom_range(0, 15) == 0);
      i_alu_ctl = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom);
      i_f3      = 3'($urandom);
      i_f7_bit6 = 1'($urandom);
      i_f7_bit0 = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       i_a = MIN_NEG;
        1:       i_a = $urandom_range(0, 15);
        default: i_a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       i_b = '0;
        1:       i_b = '1;
        2:       i_b = $urandom_range(1, 9);
        default: i_b = $urandom;
      endcase
      i_rst = ($urandom_range(0, 299) == 0);
      @(negedge i_clk); #1;
    end
    i_rst = 1'b0; i_valid = 1'b0; i_kill = 1'b0;
    repeat (40) @(negedge i_clk);
    #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
